// File: rtl/memory_stage_pkg.sv
// Shared widths, forwarding select encodings and the MEM/WB field bundle
// for the pipeline stages.
package memory_stage_pkg;
    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int JUMP_ADDR_W = 11;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_dest;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [DATA_W-1:0]     alu_result;
    } mem_wb_t;
endpackage

// File: rtl/memory_stage_data_memory.sv
// Synchronous single-port word RAM, read-before-write.
// DMEM_PARITY_EN adds a stored even-parity bit per word and a read check.
module data_memory
    import memory_stage_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 parity_bad
);
`ifdef DMEM_PARITY_EN
    logic [DATA_W:0] mem [2**ADDR_BITS];
    logic [DATA_W:0] rword;

    always_ff @(posedge clock) begin
        rword <= mem[addr];
        if (we) mem[addr] <= {^wdata, wdata};
    end

    assign rdata      = rword[DATA_W-1:0];
    assign parity_bad = (^rword[DATA_W-1:0]) != rword[DATA_W];
`else
    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clock) begin
        rdata <= mem[addr];
        if (we) mem[addr] <= wdata;
    end

    assign parity_bad = 1'b0;
`endif
endmodule

// File: rtl/memory_stage.sv
// MEM stage: data memory access, branch resolve, MEM/WB register.
// Optional DMEM_PARITY_EN enables per-word parity checking on loads.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      result_in,
    input  logic [DATA_W-1:0]      registro_2_in,
    input  logic [JUMP_ADDR_W-1:0] jump_dest_addr_in,
    input  logic                   zero_signal_in,
    input  logic [REG_ADDR_W-1:0]  reg_dest_in,
    input  logic                   MemToReg_in,
    input  logic                   RegWrite_in,
    input  logic                   MemRead_in,
    input  logic                   MemWrite_in,
    input  logic                   Branch_in,
    output logic                   pc_src_out,
    output logic [JUMP_ADDR_W-1:0] branch_target_out,
    output logic [DATA_W-1:0]      read_data_out,
    output logic [DATA_W-1:0]      alu_result_out,
    output logic [REG_ADDR_W-1:0]  reg_dest_out,
    output logic                   MemToReg_out,
    output logic                   RegWrite_out,
    output logic [DATA_W-1:0]      memory_mem_wb,
    output logic                   mem_fault_out,
    output logic                   parity_error_out
);
    logic              misaligned, out_of_range, illegal, ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_parity_bad;
    logic              rd_ok_q, fault_q;
    mem_wb_t           mem_wb_q;

    assign pc_src_out        = Branch_in & zero_signal_in;
    assign branch_target_out = jump_dest_addr_in;

    assign misaligned   = result_in[1:0] != 2'b00;
    assign out_of_range = result_in[DATA_W-1:ADDR_BITS+2] != '0;
    assign illegal      = misaligned | out_of_range;
    // Write enable is cut during reset so a store racing reset is dropped.
    assign ram_we       = MemWrite_in & ~illegal & ~reset;

    data_memory #(.ADDR_BITS(ADDR_BITS)) u_dmem (
        .clock      (clock),
        .we         (ram_we),
        .addr       (result_in[ADDR_BITS+1:2]),
        .wdata      (registro_2_in),
        .rdata      (ram_rdata),
        .parity_bad (ram_parity_bad)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_wb_q <= '0;
            rd_ok_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            mem_wb_q.reg_dest   <= reg_dest_in;
            mem_wb_q.mem_to_reg <= MemToReg_in;
            mem_wb_q.reg_write  <= RegWrite_in;
            mem_wb_q.alu_result <= result_in;
            rd_ok_q             <= MemRead_in & ~illegal;
            fault_q             <= fault_q | parity_error_out
                                 | ((MemRead_in | MemWrite_in) & illegal);
        end
    end

    // RAM output register has no reset; the qualified-read flag masks it.
    assign read_data_out    = rd_ok_q ? ram_rdata : '0;
    assign parity_error_out = rd_ok_q & ram_parity_bad;
    assign mem_fault_out    = fault_q | parity_error_out;

    assign alu_result_out = mem_wb_q.alu_result;
    assign reg_dest_out   = mem_wb_q.reg_dest;
    assign MemToReg_out   = mem_wb_q.mem_to_reg;
    assign RegWrite_out   = mem_wb_q.reg_write;
    assign memory_mem_wb  = mem_wb_q.mem_to_reg ? read_data_out : mem_wb_q.alu_result;
endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage; parity vectors run only when
// DMEM_PARITY_EN is defined.
module tb_memory_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] result_in, registro_2_in;
    logic [10:0] jump_dest_addr_in;
    logic        zero_signal_in;
    logic [4:0]  reg_dest_in;
    logic        MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
    logic        pc_src_out;
    logic [10:0] branch_target_out;
    logic [31:0] read_data_out, alu_result_out, memory_mem_wb;
    logic [4:0]  reg_dest_out;
    logic        MemToReg_out, RegWrite_out, mem_fault_out, parity_error_out;

    int n_vec = 0;
    int n_err = 0;

    memory_stage #(.ADDR_BITS(8)) dut (
        .clock(clock), .reset(reset),
        .result_in(result_in), .registro_2_in(registro_2_in),
        .jump_dest_addr_in(jump_dest_addr_in), .zero_signal_in(zero_signal_in),
        .reg_dest_in(reg_dest_in), .MemToReg_in(MemToReg_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
        .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .reg_dest_out(reg_dest_out), .MemToReg_out(MemToReg_out),
        .RegWrite_out(RegWrite_out), .memory_mem_wb(memory_mem_wb),
        .mem_fault_out(mem_fault_out), .parity_error_out(parity_error_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic m2r, input logic [4:0] rdst);
        MemRead_in    = rd;
        MemWrite_in   = wr;
        result_in     = addr;
        registro_2_in = data;
        MemToReg_in   = m2r;
        RegWrite_in   = m2r;
        reg_dest_in   = rdst;
    endtask

    initial begin
        reset = 1'b1;
        jump_dest_addr_in = '0; zero_signal_in = 1'b0; Branch_in = 1'b0;
        op(0, 0, 0, 0, 0, 0);
        step(); step();
        chk("rst_read_data", read_data_out, 32'h0);
        chk("rst_alu",       alu_result_out, 32'h0);
        chk("rst_reg_dest",  {27'h0, reg_dest_out}, 32'h0);
        chk("rst_ctl",       {29'h0, MemToReg_out, RegWrite_out, mem_fault_out}, 32'h0);
        chk("rst_parity",    {31'h0, parity_error_out}, 32'h0);
        chk("rst_mem_wb",    memory_mem_wb, 32'h0);
        reset = 1'b0;

        op(0, 1, 32'h0, 32'h0, 0, 0);               step();
        op(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);       step();
        chk("st_alu",        alu_result_out, 32'h10);
        chk("st_rd_zero",    read_data_out, 32'h0);
        op(1, 0, 32'h10, 32'h0, 1, 5'd5);           step();
        chk("ld_read_data",  read_data_out, 32'hDEADBEEF);
        chk("ld_mem_wb",     memory_mem_wb, 32'hDEADBEEF);
        chk("ld_reg_dest",   {27'h0, reg_dest_out}, 32'd5);
        chk("ld_regwrite",   {31'h0, RegWrite_out}, 32'h1);
        chk("ld_fault_clr",  {31'h0, mem_fault_out}, 32'h0);

        op(1, 0, 32'h13, 32'h0, 1, 5'd6);           step();
        chk("mis_read_zero", read_data_out, 32'h0);
        chk("mis_mem_wb",    memory_mem_wb, 32'h0);
        chk("mis_fault",     {31'h0, mem_fault_out}, 32'h1);
        chk("mis_regwrite",  {31'h0, RegWrite_out}, 32'h1);
        op(0, 0, 32'h0, 32'h0, 0, 0);               step();
        chk("fault_sticky",  {31'h0, mem_fault_out}, 32'h1);
        op(1, 0, 32'h10, 32'h0, 1, 5'd7);           step();
        chk("mis_no_corrupt", read_data_out, 32'hDEADBEEF);

        op(0, 1, 32'h400, 32'hCAFEF00D, 0, 0);      step();
        chk("oor_fault",     {31'h0, mem_fault_out}, 32'h1);
        op(1, 0, 32'h0, 32'h0, 1, 5'd8);            step();
        chk("oor_no_wrap",   read_data_out, 32'h0);
        op(0, 0, 32'h0, 32'h0, 0, 0);

        Branch_in = 1'b1; zero_signal_in = 1'b1; jump_dest_addr_in = 11'h2A5;
        #1;
        chk("br_taken",      {31'h0, pc_src_out}, 32'h1);
        chk("br_target",     {21'h0, branch_target_out}, 32'h2A5);
        zero_signal_in = 1'b0;
        #1;
        chk("br_not_zero",   {31'h0, pc_src_out}, 32'h0);
        Branch_in = 1'b0; zero_signal_in = 1'b1;
        #1;
        chk("br_no_branch",  {31'h0, pc_src_out}, 32'h0);
        zero_signal_in = 1'b0;

        op(0, 1, 32'h20, 32'h11111111, 0, 0);       step();
        op(0, 1, 32'h20, 32'h12345678, 1, 5'd9);
        reset = 1'b1;
        step();
        chk("rr_read_data",  read_data_out, 32'h0);
        chk("rr_alu",        alu_result_out, 32'h0);
        chk("rr_mem_wb",     memory_mem_wb, 32'h0);
        chk("rr_ctl",        {26'h0, reg_dest_out, MemToReg_out}, 32'h0);
        chk("rr_fault_clr",  {31'h0, mem_fault_out}, 32'h0);
        reset = 1'b0;
        op(1, 0, 32'h20, 32'h0, 1, 5'd10);          step();
        chk("rr_store_lost", memory_mem_wb, 32'h11111111);

        op(1, 1, 32'h20, 32'hAAAA5555, 1, 5'd11);   step();
        chk("rbw_old",       read_data_out, 32'h11111111);
        op(1, 0, 32'h20, 32'h0, 1, 5'd12);          step();
        chk("rbw_new",       read_data_out, 32'hAAAA5555);
        op(1, 0, 32'h20, 32'h0, 0, 5'd13);          step();
        chk("m2r0_mem_wb",   memory_mem_wb, 32'h20);
        chk("no_parity_err", {31'h0, parity_error_out}, 32'h0);
        chk("legal_no_fault", {31'h0, mem_fault_out}, 32'h0);

`ifdef DMEM_PARITY_EN
        op(0, 1, 32'h08, 32'h1, 0, 0);              step();
        op(0, 0, 32'h0, 32'h0, 0, 0);               step();
        dut.u_dmem.mem[2][32] = ~dut.u_dmem.mem[2][32];
        op(1, 0, 32'h08, 32'h0, 1, 5'd14);          step();
        chk("par_pulse",     {31'h0, parity_error_out}, 32'h1);
        chk("par_fault",     {31'h0, mem_fault_out}, 32'h1);
        chk("par_data",      read_data_out, 32'h1);
        op(0, 0, 32'h0, 32'h0, 0, 0);               step();
        chk("par_one_cycle", {31'h0, parity_error_out}, 32'h0);
        chk("par_sticky",    {31'h0, mem_fault_out}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
